// File: rtl/run_ctrl.sv
// Host-side run controller: streams a program into the core's instruction
// memory, launches the core, then times the run until done or timeout.
module run_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int INST_W  = 9,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [INST_W-1:0] ld_inst,
    input  logic              go,
    input  logic              clr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              finished,
    output logic              timed_out,
    output logic [ADDR_W:0]   load_cnt,
    output logic [15:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0]   TO_FULL  = 16'(TIMEOUT);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
    logic [15:0]         cycle_q, cycle_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INST_W-1:0]   wdata_q, wdata_d;
    logic                ld_ready_w;

    // Memory is full once the count's top bit is set (count == 2^ADDR_W).
    assign ld_ready_w = (state_q == S_LOAD) && !load_cnt_q[ADDR_W];

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        cycle_d    = cycle_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_LOAD: begin
                if (ld_valid && ld_ready_w) begin
                    we_d       = 1'b1;
                    addr_d     = load_cnt_q[ADDR_W-1:0];
                    wdata_d    = ld_inst;
                    load_cnt_d = load_cnt_q + CNT_ONE;
                end
                if (go) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cycle_d = 16'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (core_done) begin
                    state_d = S_DONE;
                end else if (cycle_q == TO_LAST) begin
                    state_d = S_TIMEOUT;
                    cycle_d = TO_FULL;
                end else begin
                    cycle_d = cycle_q + 16'd1;
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (clr) begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                end else if (go) begin
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            cycle_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            cycle_q    <= cycle_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign ld_ready    = ld_ready_w;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign core_rst    = (state_q == S_LOAD) || (state_q == S_LAUNCH);
    assign core_start  = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN);
    assign finished    = (state_q == S_DONE);
    assign timed_out   = (state_q == S_TIMEOUT);
    assign load_cnt    = load_cnt_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: load, run to done, timeout, rerun, clear,
// mid-run reset and full-memory loading, with hand-computed expectations.
module tb_run_ctrl;

    localparam int ADDR_W = 8;
    localparam int INST_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid;
    logic              ld_ready;
    logic [INST_W-1:0] ld_inst;
    logic              go;
    logic              clr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;
    logic              core_rst;
    logic              core_start;
    logic              core_done;
    logic              busy;
    logic              finished;
    logic              timed_out;
    logic [ADDR_W:0]   load_cnt;
    logic [15:0]       cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    run_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_inst(ld_inst),
        .go(go), .clr(clr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_start(core_start), .core_done(core_done),
        .busy(busy), .finished(finished), .timed_out(timed_out),
        .load_cnt(load_cnt), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed status word: {core_rst, core_start, busy, finished, timed_out, ld_ready}
    function automatic logic [5:0] status();
        return {core_rst, core_start, busy, finished, timed_out, ld_ready};
    endfunction

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_inst = '0; go = 1'b0; clr = 1'b0; core_done = 1'b0;
        tick(); tick();
        chk("reset_status", 32'(status()), 32'b100001);
        chk("reset_imem", {imem_we, 7'd0, imem_addr, 7'd0, imem_wdata}, 32'd0);
        chk("reset_cnts", {7'd0, load_cnt, cycle_count}, 32'd0);

        // Back-to-back handshakes with ld_valid held high
        rst = 1'b0; ld_valid = 1'b1; ld_inst = 9'h1A5;
        tick();
        chk("hs1", {imem_we, 3'd0, imem_addr, 3'd0, imem_wdata, 3'd0, load_cnt}, {1'b1, 3'd0, 8'd0, 3'd0, 9'h1A5, 3'd0, 9'd1});
        tick();
        chk("hs2", {imem_we, 3'd0, imem_addr, 3'd0, imem_wdata, 3'd0, load_cnt}, {1'b1, 3'd0, 8'd1, 3'd0, 9'h1A5, 3'd0, 9'd2});
        // Reset coinciding with a handshake drops the pending write
        rst = 1'b1;
        tick();
        chk("rst_drop_write", {imem_we, 22'd0, load_cnt}, 32'd0);
        rst = 1'b0; ld_valid = 1'b0;
        tick();
        chk("idle_no_write", 32'(imem_we), 32'd0);

        // Load three words
        ld_valid = 1'b1; ld_inst = 9'h001;
        tick();
        chk("ld0", {imem_we, 3'd0, imem_addr, 3'd0, imem_wdata, 3'd0, load_cnt}, {1'b1, 3'd0, 8'd0, 3'd0, 9'h001, 3'd0, 9'd1});
        ld_inst = 9'h0F2;
        tick();
        chk("ld1", {imem_we, 3'd0, imem_addr, 3'd0, imem_wdata, 3'd0, load_cnt}, {1'b1, 3'd0, 8'd1, 3'd0, 9'h0F2, 3'd0, 9'd2});
        ld_inst = 9'h1FF;
        tick();
        chk("ld2", {imem_we, 3'd0, imem_addr, 3'd0, imem_wdata, 3'd0, load_cnt}, {1'b1, 3'd0, 8'd2, 3'd0, 9'h1FF, 3'd0, 9'd3});
        ld_valid = 1'b0;
        tick();
        chk("ld_idle", {imem_we, 22'd0, load_cnt}, {1'b0, 22'd0, 9'd3});

        // Launch and run until done on the 10th RUN cycle
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("launch_status", 32'(status()), 32'b100000);
        tick();
        chk("run_status", 32'(status()), 32'b011000);
        chk("run_cnt0", 32'(cycle_count), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        chk("run_cnt9", 32'(cycle_count), 32'd9);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_status", 32'(status()), 32'b000100);
        chk("done_cnt", 32'(cycle_count), 32'd9);
        tick();
        chk("done_hold", {status(), 10'd0, cycle_count}, {6'b000100, 10'd0, 16'd9});

        // Rerun from DONE, this time letting it time out
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("rerun_launch", 32'(status()), 32'b100000);
        tick();
        chk("rerun_cnt0", {status(), 10'd0, cycle_count}, {6'b011000, 10'd0, 16'd0});
        for (int i = 0; i < 19; i++) tick();
        chk("pre_timeout", {status(), 10'd0, cycle_count}, {6'b011000, 10'd0, 16'd19});
        tick();
        chk("timeout", {status(), 10'd0, cycle_count}, {6'b000010, 10'd0, 16'd20});

        // Rerun, done on the first RUN cycle, then clr+go together
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_imm", {status(), 10'd0, cycle_count}, {6'b000100, 10'd0, 16'd0});
        clr = 1'b1; go = 1'b1;
        tick();
        clr = 1'b0; go = 1'b0;
        chk("clr_wins", {status(), 17'd0, load_cnt}, {6'b100001, 17'd0, 9'd0});
        tick();
        chk("clr_stays_load", 32'(status()), 32'b100001);

        // Empty-program launch, then reset in the middle of RUN
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("mid_run_cnt", {status(), 10'd0, cycle_count}, {6'b011000, 10'd0, 16'd4});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_run_rst", {status(), 10'd0, cycle_count}, {6'b100001, 10'd0, 16'd0});

        // Fill the whole memory
        ld_valid = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) begin
                ld_inst = 9'(i * 3 + 7);
                tick();
                if (!(imem_we === 1'b1 && imem_addr === 8'(i) && imem_wdata === 9'(i * 3 + 7)
                      && load_cnt === 9'(i + 1))) bad++;
                if (i == 254) chk("ready_at_255", 32'(ld_ready), 32'd1);
            end
            chk("fill_writes_bad", 32'(bad), 32'd0);
        end
        chk("full", {ld_ready, 22'd0, load_cnt}, {1'b0, 22'd0, 9'd256});
        tick();
        chk("overflow_no_write", {imem_we, ld_ready, 21'd0, load_cnt}, {2'b00, 21'd0, 9'd256});
        ld_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
